gcm_decrypt_verify: RTL and testbench

Receive-side counterpart of the AES-GCM encryption top. Consumes AAD and ciphertext blocks, XORs ciphertext with the AES counter-mode keystream, and streams ciphertext, AAD and the length block into the existing GHASH core. It holds recovered plaintext in an internal buffer and checks the received authentication tag. Plaintext is released downstream only after the tag matches; on mismatch the buffer is discarded.

---
 rtl/gcm_decrypt_verify.sv | 269 ++++++++++++++++++++++++++
 tb/tb_gcm_decrypt_verify.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_decrypt_verify.sv
// ---------------------------------------------------------------------------
// gcm_decrypt_verify
//   Receive side of AES-GCM. Ciphertext is XORed with the counter-mode
//   keystream and the recovered plaintext is parked in an internal buffer
//   while AAD, ciphertext and the length block are streamed into an external
//   GHASH core. Once GHASH finishes, (gh_result ^ E(K,Y0)) is compared with
//   the received tag. Plaintext is released only on a match; on a mismatch
//   the buffer is discarded.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      begins a message (sampled only in IDLE)
//   aad_total, ct_total        block counts for the message
//   tag_in                     received tag
//   aad_in/aad_byte_len        AAD block + valid bytes, aad_valid/aad_ready
//   ct_in/ct_byte_len          ciphertext block + valid bytes, ct_valid/ct_ready
//   ks_in                      keystream, E(K,Y0) first, ks_valid/ks_ready
//   gh_start/gh_input_num      one-cycle GHASH session start + block count
//   gh_data                    GHASH input block, gh_valid/gh_ready
//   gh_result/gh_done          final GHASH value and completion pulse
//   pt_out/pt_byte_len         released plaintext, pt_valid/pt_ready
//   busy                       high whenever not IDLE
//   tag_ok/tag_fail/err/done   one-cycle status pulses
// ---------------------------------------------------------------------------
module gcm_decrypt_verify #(
   parameter int MAX_BLOCKS = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [7:0]   aad_total,
   input  logic [7:0]   ct_total,
   input  logic [127:0] tag_in,
   input  logic [127:0] aad_in,
   input  logic [4:0]   aad_byte_len,
   input  logic         aad_valid,
   output logic         aad_ready,
   input  logic [127:0] ct_in,
   input  logic [4:0]   ct_byte_len,
   input  logic         ct_valid,
   output logic         ct_ready,
   input  logic [127:0] ks_in,
   input  logic         ks_valid,
   output logic         ks_ready,
   output logic         gh_start,
   output logic [8:0]   gh_input_num,
   output logic [127:0] gh_data,
   output logic         gh_valid,
   input  logic         gh_ready,
   input  logic [127:0] gh_result,
   input  logic         gh_done,
   output logic [127:0] pt_out,
   output logic [4:0]   pt_byte_len,
   output logic         pt_valid,
   input  logic         pt_ready,
   output logic         busy,
   output logic         tag_ok,
   output logic         tag_fail,
   output logic         err,
   output logic         done
);

   localparam int IW = $clog2(MAX_BLOCKS);       // buffer address width
   localparam int AW = $clog2(MAX_BLOCKS + 1);   // pointer width, holds 0..MAX_BLOCKS

   typedef enum logic [2:0] {IDLE, LOAD_Y0, AAD, CT, LEN, WAIT_TAG, RELEASE} state_t;

   state_t         state_reg, state_next;
   logic [7:0]     aad_num_reg, ct_num_reg, cnt_reg;
   logic [127:0]   tag_reg, ek_y0_reg;
   logic [63:0]    len_a_reg, len_c_reg;
   logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [127:0]   pt_out_reg;
   logic [4:0]     pt_len_reg;
   logic           pt_valid_reg, tag_ok_reg, tag_fail_reg, err_reg, done_reg;

   logic [127:0]   pt_mem [MAX_BLOCKS];
   logic [4:0]     len_mem [MAX_BLOCKS];

   logic           y0_fire, aad_fire, ct_fire, pt_fire, load_en;
   logic           aad_last, ct_last, tag_match;

   // Lengths of 16 and above mean a full block.
   function automatic logic [4:0] clamp_len(input logic [4:0] l);
      return (l > 5'd16) ? 5'd16 : l;
   endfunction

   // Keep the first l bytes, counted from [127:120] downward.
   function automatic logic [127:0] mask_blk(input logic [127:0] d, input logic [4:0] l);
      logic [127:0] m;
      m = '0;
      for (int b = 0; b < 16; b++)
         if (5'(b) < l) m[127-8*b -: 8] = 8'hff;
      return d & m;
   endfunction

   assign aad_last  = (cnt_reg == aad_num_reg - 8'd1);
   assign ct_last   = (cnt_reg == ct_num_reg - 8'd1);
   assign tag_match = ((gh_result ^ ek_y0_reg) == tag_reg);
   assign pt_fire   = pt_valid_reg & pt_ready;

   always_comb begin
      state_next   = state_reg;
      aad_ready    = 1'b0;
      ct_ready     = 1'b0;
      ks_ready     = 1'b0;
      gh_start     = 1'b0;
      gh_input_num = '0;
      gh_data      = '0;
      gh_valid     = 1'b0;
      y0_fire      = 1'b0;
      aad_fire     = 1'b0;
      ct_fire      = 1'b0;
      load_en      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start && ct_total <= 8'(MAX_BLOCKS)) state_next = LOAD_Y0;
         end
         LOAD_Y0: begin
            ks_ready = 1'b1;
            if (ks_valid) begin
               y0_fire      = 1'b1;
               gh_start     = 1'b1;
               gh_input_num = {1'b0, aad_num_reg} + {1'b0, ct_num_reg} + 9'd1;
               if (aad_num_reg != 8'd0)     state_next = AAD;
               else if (ct_num_reg != 8'd0) state_next = CT;
               else                         state_next = LEN;
            end
         end
         AAD: begin
            gh_data   = mask_blk(aad_in, clamp_len(aad_byte_len));
            gh_valid  = aad_valid;
            aad_ready = gh_ready;
            aad_fire  = aad_valid & gh_ready;
            if (aad_fire && aad_last) state_next = (ct_num_reg != 8'd0) ? CT : LEN;
         end
         CT: begin
            // All three partners must agree before anything moves, so the
            // keystream stays aligned with its ciphertext block.
            ct_fire  = ct_valid & ks_valid & gh_ready;
            ct_ready = ct_fire;
            ks_ready = ct_fire;
            gh_valid = ct_valid & ks_valid;
            gh_data  = mask_blk(ct_in, clamp_len(ct_byte_len));
            if (ct_fire && ct_last) state_next = LEN;
         end
         LEN: begin
            gh_data  = {len_a_reg, len_c_reg};
            gh_valid = 1'b1;
            if (gh_ready) state_next = WAIT_TAG;
         end
         WAIT_TAG: begin
            if (gh_done)
               state_next = (tag_match && ct_num_reg != 8'd0) ? RELEASE : IDLE;
         end
         RELEASE: begin
            load_en = (!pt_valid_reg || pt_ready) && (rd_ptr_reg != wr_ptr_reg);
            if (pt_fire && rd_ptr_reg == wr_ptr_reg) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         aad_num_reg  <= '0;
         ct_num_reg   <= '0;
         cnt_reg      <= '0;
         tag_reg      <= '0;
         ek_y0_reg    <= '0;
         len_a_reg    <= '0;
         len_c_reg    <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         pt_out_reg   <= '0;
         pt_len_reg   <= '0;
         pt_valid_reg <= 1'b0;
         tag_ok_reg   <= 1'b0;
         tag_fail_reg <= 1'b0;
         err_reg      <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         tag_ok_reg   <= 1'b0;
         tag_fail_reg <= 1'b0;
         err_reg      <= 1'b0;
         done_reg     <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (ct_total > 8'(MAX_BLOCKS)) begin
                     err_reg <= 1'b1;
                  end else begin
                     aad_num_reg <= aad_total;
                     ct_num_reg  <= ct_total;
                     tag_reg     <= tag_in;
                     len_a_reg   <= '0;
                     len_c_reg   <= '0;
                     cnt_reg     <= '0;
                     wr_ptr_reg  <= '0;
                     rd_ptr_reg  <= '0;
                  end
               end
            end
            LOAD_Y0: if (y0_fire) ek_y0_reg <= ks_in;
            AAD: begin
               if (aad_fire) begin
                  len_a_reg <= len_a_reg + {56'd0, clamp_len(aad_byte_len), 3'b000};
                  cnt_reg   <= aad_last ? 8'd0 : cnt_reg + 8'd1;
               end
            end
            CT: begin
               if (ct_fire) begin
                  len_c_reg  <= len_c_reg + {56'd0, clamp_len(ct_byte_len), 3'b000};
                  cnt_reg    <= ct_last ? 8'd0 : cnt_reg + 8'd1;
                  wr_ptr_reg <= wr_ptr_reg + AW'(1);
               end
            end
            WAIT_TAG: begin
               if (gh_done) begin
                  if (tag_match) begin
                     tag_ok_reg <= 1'b1;
                     if (ct_num_reg == 8'd0) done_reg <= 1'b1;
                  end else begin
                     tag_fail_reg <= 1'b1;
                     done_reg     <= 1'b1;
                     wr_ptr_reg   <= '0;
                  end
               end
            end
            RELEASE: begin
               if (load_en) begin
                  pt_out_reg   <= pt_mem[rd_ptr_reg[IW-1:0]];
                  pt_len_reg   <= len_mem[rd_ptr_reg[IW-1:0]];
                  pt_valid_reg <= 1'b1;
                  rd_ptr_reg   <= rd_ptr_reg + AW'(1);
               end else if (pt_fire) begin
                  pt_valid_reg <= 1'b0;
               end
               if (pt_fire && rd_ptr_reg == wr_ptr_reg) begin
                  done_reg   <= 1'b1;
                  wr_ptr_reg <= '0;
                  rd_ptr_reg <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Plaintext buffer: plain RAM, no reset; emptiness is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (ct_fire) begin
         pt_mem[wr_ptr_reg[IW-1:0]]  <= mask_blk(ct_in ^ ks_in, clamp_len(ct_byte_len));
         len_mem[wr_ptr_reg[IW-1:0]] <= clamp_len(ct_byte_len);
      end
   end

   assign pt_out      = pt_out_reg;
   assign pt_byte_len = pt_len_reg;
   assign pt_valid    = pt_valid_reg;
   assign tag_ok      = tag_ok_reg;
   assign tag_fail    = tag_fail_reg;
   assign err         = err_reg;
   assign done        = done_reg;
   assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_gcm_decrypt_verify.sv
// ---------------------------------------------------------------------------
// tb_gcm_decrypt_verify
//   Directed vectors with hand-computed expectations. Stimulus pushes the
//   expected GHASH blocks, status pulses and plaintext blocks into queues; a
//   monitor pops and compares whenever the DUT presents a handshake or pulse.
//   A small GHASH stand-in accepts blocks and returns a preset result.
// ---------------------------------------------------------------------------
module tb_gcm_decrypt_verify;

   localparam logic [127:0] KS0   = 128'h58e2fccefa7e3061367f1d57a4e7455a;
   localparam logic [127:0] C2_CT = 128'h0388dace60b6a392f328c2b971b2fe78;
   localparam logic [127:0] C2_GH = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
   localparam logic [127:0] C2_T  = 128'hab6e47d42cec13bdf53a67b21257bddf;

   logic         clk = 1'b0;
   logic         rst_n, start;
   logic [7:0]   aad_total, ct_total;
   logic [127:0] tag_in, aad_in, ct_in, ks_in, gh_data, gh_result, pt_out;
   logic [4:0]   aad_byte_len, ct_byte_len, pt_byte_len;
   logic         aad_valid, aad_ready, ct_valid, ct_ready, ks_valid, ks_ready;
   logic         gh_start, gh_valid, gh_ready, gh_done;
   logic [8:0]   gh_input_num;
   logic         pt_valid, pt_ready, busy, tag_ok, tag_fail, err, done;

   gcm_decrypt_verify #(.MAX_BLOCKS(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .aad_total(aad_total), .ct_total(ct_total), .tag_in(tag_in),
      .aad_in(aad_in), .aad_byte_len(aad_byte_len), .aad_valid(aad_valid), .aad_ready(aad_ready),
      .ct_in(ct_in), .ct_byte_len(ct_byte_len), .ct_valid(ct_valid), .ct_ready(ct_ready),
      .ks_in(ks_in), .ks_valid(ks_valid), .ks_ready(ks_ready),
      .gh_start(gh_start), .gh_input_num(gh_input_num), .gh_data(gh_data),
      .gh_valid(gh_valid), .gh_ready(gh_ready), .gh_result(gh_result), .gh_done(gh_done),
      .pt_out(pt_out), .pt_byte_len(pt_byte_len), .pt_valid(pt_valid), .pt_ready(pt_ready),
      .busy(busy), .tag_ok(tag_ok), .tag_fail(tag_fail), .err(err), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // scoreboard queues
   logic [127:0] exp_gh[$];
   logic [3:0]   exp_stat[$];      // {tag_ok, tag_fail, err, done}
   logic [132:0] exp_pt[$];        // {len, block}
   int           exp_gh_num = 0;
   logic [127:0] ghash_ret = '0;
   bit           stall_en = 0;
   bit           abort = 0;
   bit           tag_seen = 0;
   int           ct_hs = 0;

   // per-test vectors
   logic [127:0] aad_blk[4], ct_blk[4], ks_blk[5];
   logic [4:0]   aad_len[4], ct_len[4];

   task automatic chk(input string name, input logic [135:0] act, input logic [135:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=event required=none", name);
   endtask

   // GHASH stand-in and pt_ready driver
   initial begin
      int cnt;
      bit hs;
      cnt = 0; gh_ready = 1'b0; gh_done = 1'b0; gh_result = '0; pt_ready = 1'b0;
      forever begin
         @(negedge clk);
         hs = gh_valid && gh_ready;
         @(posedge clk); #1;
         gh_done = 1'b0;
         if (!rst_n) cnt = 0;
         else if (hs) begin
            cnt++;
            if (cnt == exp_gh_num) begin
               gh_done = 1'b1;
               gh_result = ghash_ret;
               cnt = 0;
            end
         end
         gh_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
         pt_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // monitor
   initial begin
      logic [3:0] st;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (gh_start) begin
               chk("gh_input_num", {127'd0, gh_input_num}, 136'(exp_gh_num));
               tag_seen = 0;
               ct_hs = 0;
            end
            if (ct_valid && ct_ready) ct_hs++;
            if (gh_valid && gh_ready) begin
               if (exp_gh.size() == 0) fail_now("gh_unexpected");
               else chk("gh_data", {8'd0, gh_data}, {8'd0, exp_gh.pop_front()});
            end
            st = {tag_ok, tag_fail, err, done};
            if (st != 4'b0) begin
               if (tag_ok) tag_seen = 1;
               $display("status pulse %b", st);
               if (exp_stat.size() == 0) fail_now("status_unexpected");
               else chk("status", {132'd0, st}, {132'd0, exp_stat.pop_front()});
               if (done || tag_fail) chk("busy_after_end", {135'd0, busy}, 136'd0);
            end
            if (pt_valid) begin
               chk("pt_after_tag_ok", {135'd0, tag_seen}, 136'd1);
               if (pt_ready) begin
                  $display("pt handshake len=%0d data=%h", pt_byte_len, pt_out);
                  if (exp_pt.size() == 0) fail_now("pt_unexpected");
                  else chk("pt_block", {3'd0, pt_byte_len, pt_out}, {3'd0, exp_pt.pop_front()});
               end
            end
         end
      end
   end

   task automatic drive_ks(input int n);
      for (int i = 0; i < n && !abort; i++) begin
         bit hs; int g;
         while (stall_en && $urandom_range(0, 2) == 0 && !abort) begin @(posedge clk); #1; end
         ks_in = ks_blk[i]; ks_valid = 1'b1; hs = 0; g = 0;
         while (!hs && !abort && g < 2000) begin @(negedge clk); hs = ks_ready; @(posedge clk); #1; g++; end
         if (!hs && !abort) fail_now("ks_timeout");
         ks_valid = 1'b0;
         if (!hs) break;
      end
   endtask

   task automatic drive_aad(input int n);
      for (int i = 0; i < n && !abort; i++) begin
         bit hs; int g;
         aad_in = aad_blk[i]; aad_byte_len = aad_len[i]; aad_valid = 1'b1; hs = 0; g = 0;
         while (!hs && !abort && g < 2000) begin @(negedge clk); hs = aad_ready; @(posedge clk); #1; g++; end
         if (!hs && !abort) fail_now("aad_timeout");
         aad_valid = 1'b0;
         if (!hs) break;
      end
   endtask

   task automatic drive_ct(input int n);
      for (int i = 0; i < n && !abort; i++) begin
         bit hs; int g;
         while (stall_en && $urandom_range(0, 2) == 0 && !abort) begin @(posedge clk); #1; end
         ct_in = ct_blk[i]; ct_byte_len = ct_len[i]; ct_valid = 1'b1; hs = 0; g = 0;
         while (!hs && !abort && g < 2000) begin @(negedge clk); hs = ct_ready; @(posedge clk); #1; g++; end
         if (!hs && !abort) fail_now("ct_timeout");
         ct_valid = 1'b0;
         if (!hs) break;
      end
   endtask

   task automatic pulse_start(input int na, input int nc, input logic [127:0] tag);
      @(posedge clk); #1;
      start = 1'b1; aad_total = 8'(na); ct_total = 8'(nc); tag_in = tag;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int c;
      c = 0;
      while ((exp_stat.size() != 0 || exp_pt.size() != 0 || busy) && c < 3000) begin
         @(negedge clk); c++;
      end
      if (c >= 3000) fail_now({name, "_timeout"});
      repeat (3) @(negedge clk);
      chk({name, "_gh_left"}, 136'(exp_gh.size()), 136'd0);
   endtask

   task automatic run_msg(input string name, input int na, input int nc,
                          input logic [127:0] tag, input logic [127:0] ret);
      $display("message %s aad=%0d ct=%0d", name, na, nc);
      exp_gh_num = na + nc + 1;
      ghash_ret = ret;
      pulse_start(na, nc, tag);
      fork
         drive_ks(nc + 1);
         drive_aad(na);
         drive_ct(nc);
      join
      wait_idle(name);
   endtask

   task automatic chk_outputs_zero(input string name);
      chk({name, "_ctl"}, {118'd0, busy, aad_ready, ct_ready, ks_ready, gh_start, gh_valid,
                           gh_input_num, pt_valid, pt_byte_len},  136'd0);
      chk({name, "_pulses"}, {132'd0, tag_ok, tag_fail, err, done}, 136'd0);
      chk({name, "_gh_data"}, {8'd0, gh_data}, 136'd0);
      chk({name, "_pt_out"}, {8'd0, pt_out}, 136'd0);
   endtask

   task automatic setup_case1();
      ks_blk[0] = KS0;
      exp_gh.push_back(128'd0);
      exp_stat.push_back(4'b1001);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; aad_total = '0; ct_total = '0; tag_in = '0;
      aad_in = '0; aad_byte_len = '0; aad_valid = 1'b0;
      ct_in = '0; ct_byte_len = '0; ct_valid = 1'b0; ks_in = '0; ks_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      rst_n = 1'b1;

      // NIST case 1
      setup_case1();
      run_msg("case1", 0, 0, KS0, 128'd0);

      // NIST case 2
      ks_blk[0] = KS0; ks_blk[1] = C2_CT;
      ct_blk[0] = C2_CT; ct_len[0] = 5'd16;
      exp_gh.push_back(C2_CT);
      exp_gh.push_back({64'd0, 64'd128});
      exp_stat.push_back(4'b1000);
      exp_pt.push_back({5'd16, 128'd0});
      exp_stat.push_back(4'b0001);
      run_msg("case2", 0, 1, C2_T, C2_GH);

      // case 2 with tag bit 0 flipped
      exp_gh.push_back(C2_CT);
      exp_gh.push_back({64'd0, 64'd128});
      exp_stat.push_back(4'b0101);
      run_msg("case2_badtag", 0, 1, C2_T ^ 128'd1, C2_GH);

      // 2 AAD + 3 CT with stalls
      stall_en = 1;
      aad_blk[0] = 128'hfeedfacedeadbeeffeedfacedeadbeef; aad_len[0] = 5'd16;
      aad_blk[1] = 128'habaddad2aabbccddeeff001122334455; aad_len[1] = 5'd4;
      ct_blk[0]  = 128'h00112233445566778899aabbccddeeff; ct_len[0]  = 5'd16;
      ct_blk[1]  = 128'h0123456789abcdef0123456789abcdef; ct_len[1]  = 5'd20;
      ct_blk[2]  = 128'hdeadbeefcafebabe1234567855aa55aa; ct_len[2]  = 5'd12;
      ks_blk[0]  = KS0;
      ks_blk[1]  = 128'hffffffffffffffffffffffffffffffff;
      ks_blk[2]  = 128'h0123456789abcdef0000000000000000;
      ks_blk[3]  = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
      exp_gh.push_back(128'hfeedfacedeadbeeffeedfacedeadbeef);
      exp_gh.push_back(128'habaddad2000000000000000000000000);
      exp_gh.push_back(128'h00112233445566778899aabbccddeeff);
      exp_gh.push_back(128'h0123456789abcdef0123456789abcdef);
      exp_gh.push_back(128'hdeadbeefcafebabe1234567800000000);
      exp_gh.push_back({64'd160, 64'd352});
      exp_stat.push_back(4'b1000);
      exp_pt.push_back({5'd16, 128'hffeeddccbbaa99887766554433221100});
      exp_pt.push_back({5'd16, 128'h00000000000000000123456789abcdef});
      exp_pt.push_back({5'd12, 128'hd1a2b1e0c5f1b5b11d3b597700000000});
      exp_stat.push_back(4'b0001);
      run_msg("stall", 2, 3, 128'h00112233445566778899aabbccddeeff ^ KS0,
              128'h00112233445566778899aabbccddeeff);
      stall_en = 0;

      // ct_total above MAX_BLOCKS
      $display("message err ct=17");
      exp_stat.push_back(4'b0010);
      pulse_start(0, 17, 128'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("err_busy", {135'd0, busy}, 136'd0);
      end
      wait_idle("err");

      // reset mid-CT on the 2nd block
      $display("message reset_mid_ct");
      exp_gh_num = 4;
      pulse_start(0, 3, 128'd0);
      fork
         drive_ks(4);
         drive_ct(3);
      join_none
      begin
         int c;
         c = 0;
         while (ct_hs < 1 && c < 200) begin @(negedge clk); c++; end
         if (c >= 200) fail_now("reset_wait_timeout");
      end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk_outputs_zero("async_reset");
      abort = 1;
      repeat (4) @(posedge clk);
      #1;
      exp_gh.delete(); exp_stat.delete(); exp_pt.delete();
      abort = 0;
      ks_valid = 1'b0; ct_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // fresh case 1 after reset
      setup_case1();
      run_msg("case1_after_reset", 0, 0, KS0, 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
